// File: rtl/freq_sweep_pkg.sv
// Shared types and helpers for the frequency sweep controller.
package freq_sweep_pkg;

    localparam int unsigned FREQ_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StEval,
        StDone
    } sweep_state_e;

    // Smallest n with 2**n >= val; exact log2 for powers of two.
    function automatic int unsigned clog2_u(input int unsigned val);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/freq_sweep_ctrl_mag_avg.sv
// Magnitude averager: sums exactly ACC_LEN qualified samples, then presents the truncated mean.
module mag_avg
    import freq_sweep_pkg::*;
#(
    parameter int unsigned ACC_LEN = 16,
    parameter int unsigned MAG_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [MAG_W-1:0] mag_i,
    output logic             ready_o,
    output logic [MAG_W-1:0] avg_o
);

    localparam int unsigned SHIFT = clog2_u(ACC_LEN);
    localparam int unsigned SUM_W = MAG_W + SHIFT;
    localparam int unsigned CNT_W = SHIFT + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ACC_LEN);

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (en_i && valid_i && !ready_o) begin
            sum_d = sum_q + SUM_W'(mag_i);
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign ready_o = (cnt_q == CNT_FULL);
    assign avg_o   = MAG_W'(sum_q >> SHIFT);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Stepped frequency sweep: settle, average the response, track the peak, advance until f_stop.
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int unsigned ACC_LEN = 16,
    parameter int unsigned MAG_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [FREQ_W-1:0] f_start_i,
    input  logic [FREQ_W-1:0] f_stop_i,
    input  logic [FREQ_W-1:0] f_step_i,
    input  logic [31:0]       settle_cycles_i,
    input  logic [MAG_W-1:0]  mag_i,
    input  logic              mag_valid_i,
    output logic [FREQ_W-1:0] freq_val_o,
    output logic              freq_upd_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [FREQ_W-1:0] peak_freq_o,
    output logic [MAG_W-1:0]  peak_mag_o
);

    sweep_state_e state_q, state_d;

    logic [FREQ_W-1:0] f_stop_q, f_stop_d;
    logic [FREQ_W-1:0] f_step_q, f_step_d;
    logic [31:0]       settle_q, settle_d;
    logic [31:0]       settle_cnt_q, settle_cnt_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              upd_q, upd_d;
    logic              err_q, err_d;
    logic [FREQ_W-1:0] peak_freq_q, peak_freq_d;
    logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;

    logic              start_ok;
    logic              abort_busy;
    logic              settle_last;
    logic [FREQ_W:0]   next_freq;
    logic              sweep_end;
    logic              acc_clear;
    logic              acc_en;
    logic              acc_ready;
    logic [MAG_W-1:0]  avg;

    assign start_ok    = (f_step_i != '0) && (f_start_i <= f_stop_i);
    assign abort_busy  = abort_i && (state_q inside {StSettle, StMeasure, StEval});
    assign settle_last = (settle_q == '0) || (settle_cnt_q >= settle_q - 32'd1);
    // One extra bit so a step past 2**32-1 ends the sweep instead of wrapping.
    assign next_freq   = {1'b0, freq_q} + {1'b0, f_step_q};
    assign sweep_end   = next_freq > {1'b0, f_stop_q};
    assign acc_en      = (state_q == StMeasure);

    mag_avg #(
        .ACC_LEN (ACC_LEN),
        .MAG_W   (MAG_W)
    ) u_mag_avg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (acc_clear),
        .en_i    (acc_en),
        .valid_i (mag_valid_i),
        .mag_i   (mag_i),
        .ready_o (acc_ready),
        .avg_o   (avg)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_i && start_ok) state_d = StSettle;
            StSettle:  if (settle_last) state_d = StMeasure;
            StMeasure: if (acc_ready) state_d = StEval;
            StEval:    state_d = sweep_end ? StDone : StSettle;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (abort_busy) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        f_stop_d     = f_stop_q;
        f_step_d     = f_step_q;
        settle_d     = settle_q;
        settle_cnt_d = settle_cnt_q;
        freq_d       = freq_q;
        upd_d        = 1'b0;
        err_d        = 1'b0;
        peak_freq_d  = peak_freq_q;
        peak_mag_d   = peak_mag_q;
        acc_clear    = 1'b0;
        if (!abort_busy) begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && start_ok) begin
                        f_stop_d     = f_stop_i;
                        f_step_d     = f_step_i;
                        settle_d     = settle_cycles_i;
                        settle_cnt_d = '0;
                        freq_d       = f_start_i;
                        upd_d        = 1'b1;
                        peak_freq_d  = f_start_i;
                        peak_mag_d   = '0;
                        acc_clear    = 1'b1;
                    end else if (start_i) begin
                        err_d = 1'b1;
                    end
                end
                StSettle: settle_cnt_d = settle_cnt_q + 32'd1;
                StEval: begin
                    // Strictly greater: on a tie the earlier (lower) frequency wins.
                    if (avg > peak_mag_q) begin
                        peak_mag_d  = avg;
                        peak_freq_d = freq_q;
                    end
                    if (!sweep_end) begin
                        freq_d       = next_freq[FREQ_W-1:0];
                        upd_d        = 1'b1;
                        settle_cnt_d = '0;
                        acc_clear    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            f_stop_q     <= '0;
            f_step_q     <= '0;
            settle_q     <= '0;
            settle_cnt_q <= '0;
            freq_q       <= '0;
            upd_q        <= 1'b0;
            err_q        <= 1'b0;
            peak_freq_q  <= '0;
            peak_mag_q   <= '0;
        end else begin
            f_stop_q     <= f_stop_d;
            f_step_q     <= f_step_d;
            settle_q     <= settle_d;
            settle_cnt_q <= settle_cnt_d;
            freq_q       <= freq_d;
            upd_q        <= upd_d;
            err_q        <= err_d;
            peak_freq_q  <= peak_freq_d;
            peak_mag_q   <= peak_mag_d;
        end
    end

    always_comb begin
        busy_o      = state_q inside {StSettle, StMeasure, StEval};
        done_o      = (state_q == StDone);
        freq_val_o  = freq_q;
        freq_upd_o  = upd_q;
        err_o       = err_q;
        peak_freq_o = peak_freq_q;
        peak_mag_o  = peak_mag_q;
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: vector table of whole sweeps plus corner-case sequences.
module tb_freq_sweep_ctrl;

    localparam int unsigned ACC_LEN = 4;
    localparam int unsigned MAG_W   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] f_start = '0, f_stop = '0, f_step = '0, settle = '0;
    logic [15:0] mag;
    logic        mag_valid;
    logic [31:0] freq_val, peak_freq;
    logic        freq_upd, busy, done, err;
    logic [15:0] peak_mag;

    always #5 clk = ~clk;

    freq_sweep_ctrl #(
        .ACC_LEN (ACC_LEN),
        .MAG_W   (MAG_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .abort_i         (abort),
        .f_start_i       (f_start),
        .f_stop_i        (f_stop),
        .f_step_i        (f_step),
        .settle_cycles_i (settle),
        .mag_i           (mag),
        .mag_valid_i     (mag_valid),
        .freq_val_o      (freq_val),
        .freq_upd_o      (freq_upd),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .peak_freq_o     (peak_freq),
        .peak_mag_o      (peak_mag)
    );

    int n_checks = 0, n_pass = 0;
    int mag_mode = 0, vmode = 0, vcnt = 0, cyc = 0;
    int upd_cnt = 0, done_cnt = 0, err_cnt = 0, consec = 0, err_consec = 0;
    int upd_cyc = 0, done_cyc = 0;
    logic prev_upd = 1'b0, prev_err = 1'b0;

    // Response model: magnitude depends only on the frequency currently driven.
    function automatic int mag_of(input int mode, input logic [31:0] f);
        case (mode)
            1:       return (f == 32'd1020) ? 900 : 100;
            2:       return (f == 32'd1010 || f == 32'd1030) ? 700 : 100;
            3:       return (f == 32'd1000) ? 300 : (f == 32'd1010) ? 400 : 900;
            default: return 500;
        endcase
    endfunction

    assign mag       = 16'(mag_of(mag_mode, freq_val));
    assign mag_valid = (vmode == 0) || (vcnt == 0);

    always @(negedge clk) begin
        cyc  = cyc + 1;
        vcnt = (vcnt == 2) ? 0 : vcnt + 1;
        if (freq_upd) begin
            upd_cnt = upd_cnt + 1;
            upd_cyc = cyc;
            if (prev_upd) consec = consec + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err) begin
            err_cnt = err_cnt + 1;
            if (prev_err) err_consec = err_consec + 1;
        end
        prev_upd = freq_upd;
        prev_err = err;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        upd_cnt  = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] fst,
                             input logic [31:0] st, input int mm, input int vm,
                             output int timed_out);
        clear_mon();
        f_start  = fs;
        f_stop   = fe;
        f_step   = fst;
        settle   = st;
        mag_mode = mm;
        vmode    = vm;
        start    = 1'b1;
        tick(1);
        start = 1'b0;
        timed_out = 1;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > 0 || err_cnt > 0) begin
                timed_out = 0;
                break;
            end
            tick(1);
        end
        tick(3);
    endtask

    typedef struct {
        logic [31:0] fs, fe, fst, st;
        int          mm, vm;
        int          e_upd, e_done, e_err;
        logic [31:0] e_pf;
        int          e_pm;
        logic [31:0] e_fv;
    } vec_t;

    vec_t vecs[8];
    int   to;
    int   lat[4];
    int   svals[4] = '{0, 1, 4, 8};

    initial begin
        vecs[0] = '{32'd1000, 32'd1040, 32'd10, 32'd4, 0, 0, 5, 1, 0, 32'd1000, 500, 32'd1040};
        vecs[1] = '{32'd1000, 32'd1040, 32'd10, 32'd4, 1, 0, 5, 1, 0, 32'd1020, 900, 32'd1040};
        vecs[2] = '{32'd1000, 32'd1040, 32'd10, 32'd4, 2, 0, 5, 1, 0, 32'd1010, 700, 32'd1040};
        vecs[3] = '{32'd1000, 32'd1040, 32'd0,  32'd4, 0, 0, 0, 0, 1, 32'd1010, 700, 32'd1040};
        vecs[4] = '{32'd2000, 32'd1000, 32'd10, 32'd4, 0, 0, 0, 0, 1, 32'd1010, 700, 32'd1040};
        vecs[5] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 32'd4, 0, 0, 1, 1, 0,
                    32'hFFFF_FFF0, 500, 32'hFFFF_FFF0};
        vecs[6] = '{32'd1000, 32'd1040, 32'd10, 32'd0, 1, 1, 5, 1, 0, 32'd1020, 900, 32'd1040};
        vecs[7] = '{32'd5000, 32'd5000, 32'd1,  32'd0, 0, 0, 1, 1, 0, 32'd5000, 500, 32'd5000};

        // Reset with a valid start held: nothing may be accepted.
        f_start = 32'd1000;
        f_stop  = 32'd1040;
        f_step  = 32'd10;
        settle  = 32'd4;
        start   = 1'b1;
        tick(3);
        chk("reset freq_val", freq_val, 0);
        chk("reset freq_upd", freq_upd, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset peak_freq", peak_freq, 0);
        chk("reset peak_mag", peak_mag, 0);
        chk("reset upd count", upd_cnt, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 8; i++) begin
            run_sweep(vecs[i].fs, vecs[i].fe, vecs[i].fst, vecs[i].st, vecs[i].mm, vecs[i].vm, to);
            chk($sformatf("row%0d timeout", i), to, 0);
            chk($sformatf("row%0d upd count", i), upd_cnt, vecs[i].e_upd);
            chk($sformatf("row%0d done count", i), done_cnt, vecs[i].e_done);
            chk($sformatf("row%0d err count", i), err_cnt, vecs[i].e_err);
            chk($sformatf("row%0d peak_freq", i), peak_freq, vecs[i].e_pf);
            chk($sformatf("row%0d peak_mag", i), peak_mag, vecs[i].e_pm);
            chk($sformatf("row%0d freq_val", i), freq_val, vecs[i].e_fv);
            chk($sformatf("row%0d busy after", i), busy, 0);
        end

        // Settle length: latency differences follow settle_cycles, with 0 behaving as 1.
        for (int i = 0; i < 4; i++) begin
            run_sweep(32'd5000, 32'd5000, 32'd1, svals[i], 0, 0, to);
            chk($sformatf("settle%0d timeout", svals[i]), to, 0);
            lat[i] = done_cyc - upd_cyc;
        end
        chk("settle 1 vs 0", lat[1] - lat[0], 0);
        chk("settle 4 vs 1", lat[2] - lat[1], 3);
        chk("settle 8 vs 4", lat[3] - lat[2], 4);

        // Start and parameter changes while busy are ignored.
        clear_mon();
        f_start  = 32'd1000;
        f_stop   = 32'd1040;
        f_step   = 32'd10;
        settle   = 32'd4;
        mag_mode = 1;
        vmode    = 0;
        start    = 1'b1;
        tick(1);
        f_start = 32'd50;
        f_stop  = 32'd9000;
        f_step  = 32'd1;
        settle  = 32'd0;
        tick(5);
        start = 1'b0;
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > 0) begin
                to = 0;
                break;
            end
            tick(1);
        end
        tick(3);
        chk("busy-change timeout", to, 0);
        chk("busy-change upd count", upd_cnt, 5);
        chk("busy-change peak_freq", peak_freq, 1020);
        chk("busy-change freq_val", freq_val, 1040);

        // Abort in MEASURE of the third point (1020).
        clear_mon();
        f_start  = 32'd1000;
        f_stop   = 32'd1040;
        f_step   = 32'd10;
        settle   = 32'd4;
        mag_mode = 3;
        start    = 1'b1;
        tick(1);
        start = 1'b0;
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            if (upd_cnt >= 3) begin
                to = 0;
                break;
            end
            tick(1);
        end
        chk("abort reach timeout", to, 0);
        tick(5);
        chk("abort pre busy", busy, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort busy next", busy, 0);
        tick(20);
        chk("abort done count", done_cnt, 0);
        chk("abort upd count", upd_cnt, 3);
        chk("abort peak_freq", peak_freq, 1010);
        chk("abort peak_mag", peak_mag, 400);
        chk("abort freq_val", freq_val, 1020);

        // Reset mid-sweep clears outputs; next sweep starts from a clean accumulator.
        clear_mon();
        mag_mode = 1;
        start    = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        rst_n = 1'b0;
        tick(1);
        chk("midrst freq_val", freq_val, 0);
        chk("midrst busy", busy, 0);
        chk("midrst peak_freq", peak_freq, 0);
        chk("midrst peak_mag", peak_mag, 0);
        chk("midrst freq_upd", freq_upd, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        run_sweep(32'd1000, 32'd1040, 32'd10, 32'd4, 0, 0, to);
        chk("postrst timeout", to, 0);
        chk("postrst upd count", upd_cnt, 5);
        chk("postrst peak_mag", peak_mag, 500);
        chk("postrst peak_freq", peak_freq, 1000);

        chk("freq_upd back-to-back", consec, 0);
        chk("err back-to-back", err_consec, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACC_LEN, default 16, the number of magnitude samples averaged per point (power of 2, 2..256).
REQ-002 SHALL have parameter MAG_W, default 16, the magnitude sample width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 start  in  1  level sampled in IDLE; launches a sweep.
REQ-007 abort  in  1  ends a sweep in progress, returning to IDLE without done.
REQ-008 f_start, f_stop, f_step  in  32 each  sweep bounds and increment, in Hz.
REQ-009 settle_cycles  in  32  clocks to wait after each frequency update.
REQ-010 mag  in  MAG_W  response magnitude sample, unsigned.
REQ-011 mag_valid  in  1  mag qualifier.
REQ-012 freq_val  out  32  frequency word to the square-wave generator.
REQ-013 freq_upd  out  1  one-cycle strobe when freq_val changes.
REQ-014 busy  out  1  high from start acceptance until done/abort.
REQ-015 done  out  1  one-cycle pulse at normal sweep completion.
REQ-016 err  out  1  one-cycle pulse on a rejected start.
REQ-017 peak_freq  out  32  frequency of the largest averaged magnitude.
REQ-018 peak_mag  out  MAG_W  that largest averaged magnitude.

Function
REQ-019 States SHALL be IDLE, SETTLE, MEASURE, EVAL, DONE.
REQ-020 In IDLE, start=1 with f_step!=0 and f_start<=f_stop SHALL latch f_start/f_stop/f_step/settle_cycles, set freq_val=f_start, pulse freq_upd, set busy, clear peak_mag to 0, set peak_freq=f_start, and go to SETTLE next cycle.
REQ-021 In IDLE, start=1 with f_step==0 or f_start>f_stop SHALL pulse err one cycle, stay IDLE, and leave freq_val and peak outputs unchanged.
REQ-022 start while busy SHALL be ignored; input parameter changes while busy SHALL have no effect.
REQ-023 SETTLE SHALL last exactly settle_cycles clocks (0 means 1 clock), ignoring mag_valid, then go to MEASURE.
REQ-024 MEASURE SHALL sum exactly ACC_LEN samples with mag_valid=1 into a MAG_W+log2(ACC_LEN)-bit accumulator without overflow, then go to EVAL.
REQ-025 EVAL (1 clock) SHALL compute avg = sum >> log2(ACC_LEN) (truncating) and update peak_mag/peak_freq only if avg > peak_mag strictly, so ties keep the lower frequency.
REQ-026 In EVAL, if freq_val+f_step, computed in 33 bits, is greater than f_stop, the block SHALL go to DONE; otherwise it SHALL load freq_val+f_step, pulse freq_upd, and go to SETTLE.
REQ-027 DONE SHALL pulse done one cycle, drop busy in the same cycle, and return to IDLE; freq_val and peak outputs SHALL hold until the next accepted start.
REQ-028 abort=1 in any busy state SHALL go to IDLE next cycle with busy=0 and no done; peak outputs SHALL hold partial results; abort has priority over all transitions.
REQ-029 f_start==f_stop SHALL produce a single-point sweep.
REQ-030 freq_upd SHALL never be high in two consecutive cycles.

Reset
REQ-031 rst=0 SHALL force IDLE and set every output to 0: freq_val, freq_upd, busy, done, err, peak_freq, peak_mag.
REQ-032 Reset mid-sweep SHALL discard all latched parameters and accumulator contents; a start is not accepted while rst=0.

Structure
REQ-033 Package freq_sweep_pkg SHALL hold the state enumeration, the 32-bit frequency width constant and the log2 helper.
REQ-034 A sub-module mag_avg (clear, accumulate on valid, count, sum-ready flag) SHALL implement REQ-024/025 averaging.

Verification
REQ-035 Sweep f_start=1000, f_stop=1040, f_step=10, settle=4, mag constant: 5 freq_upd strobes (1000..1040), done once, busy low after.
REQ-036 Same sweep with mag peaking at 1020 (avg 900, others 100): peak_freq=1020, peak_mag=900; equal peaks at 1010 and 1030 give peak_freq=1010.
REQ-037 f_step=0, or f_start=2000 with f_stop=1000: err pulses one cycle, busy stays 0, no freq_upd.
REQ-038 f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_step=0x20: single point, no wrap, done.
REQ-039 abort during MEASURE at the third point: IDLE next cycle, no done, peak holds the best of the first two points.
REQ-040 mag_valid toggled every 3rd cycle, settle_cycles=0: exactly ACC_LEN samples counted per point; rst=0 mid-sweep clears all outputs.
